// File: rtl/pg_scheduler.sv
// pg_scheduler: frame-synchronous pattern scheduler for the VGA path.
// Selects the displayed pattern and its configuration from manual switches, a
// debounced advance button, or an automatic slideshow. All changes are applied
// only at a valid vertical-sync boundary so a frame never tears.
//
// Ports:
//   clock        pixel clock
//   rst          asynchronous active-high reset
//   vSync        vertical sync (same clock domain)
//   vActive      vertical active-video flag
//   SW[9:0]      [9] auto enable, [8] freeze, [7:3] config, [2:0] manual index
//   KEY_ADV      raw advance button, active-low, asynchronous
//   pattern      pattern index to the pattern generator
//   cfg          latched copy of SW[7:3]
//   auto_mode    high while in AUTO
//   frame_start  one-cycle pulse per valid frame boundary
//   frame_count  valid boundaries since reset (wraps)
//   timing_err   sticky: vSync edge seen while vActive was high
module pg_scheduler #(
  parameter int unsigned NUM_PATTERNS    = 8,
  parameter int unsigned FRAMES_PER_STEP = 60,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          VS_ACTIVE_LOW   = 1'b1
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        vSync,
  input  logic        vActive,
  input  logic [9:0]  SW,
  input  logic        KEY_ADV,
  output logic [2:0]  pattern,
  output logic [4:0]  cfg,
  output logic        auto_mode,
  output logic        frame_start,
  output logic [15:0] frame_count,
  output logic        timing_err
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned STEP_W = 16;
  localparam int unsigned PAT_W  = 3;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_AUTO   = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              vs_d;
  logic              edge_c, boundary_c;
  logic              key_meta, key_sync, key_level;
  logic [DB_W-1:0]   db_cnt;
  logic              press_c, adv_pending, adv_c;
  logic [STEP_W-1:0] step, step_n, step_base;
  logic [PAT_W-1:0]  pattern_n, pat_inc, pat_sel;
  logic [4:0]        cfg_n;

  // Frame boundary detection; edges during active video are flagged, not used
  always_comb begin
    edge_c     = VS_ACTIVE_LOW ? (vs_d & ~vSync) : (~vs_d & vSync);
    boundary_c = edge_c & ~vActive;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      vs_d <= VS_ACTIVE_LOW;
    end else begin
      vs_d <= vSync;
    end
  end

  // Button synchronizer and debounce; accepted level idles high (released)
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      key_meta  <= 1'b1;
      key_sync  <= 1'b1;
      key_level <= 1'b1;
      db_cnt    <= '0;
    end else begin
      key_meta <= KEY_ADV;
      key_sync <= key_meta;
      if (key_sync != key_level) begin
        if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          key_level <= key_sync;
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Press = accepted high-to-low transition, visible in the cycle it is accepted
  always_comb begin
    press_c = (key_sync != key_level) && !key_sync &&
              (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    adv_c   = adv_pending | press_c;
  end

  // Presses collapse into one pending advance, consumed at every boundary
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      adv_pending <= 1'b0;
    end else if (boundary_c) begin
      adv_pending <= 1'b0;
    end else if (press_c) begin
      adv_pending <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= ST_MANUAL;
    end else begin
      state <= state_n;
    end
  end

  // Next state and next pattern/config/step, evaluated only at a boundary
  always_comb begin
    state_n   = state;
    pattern_n = pattern;
    cfg_n     = cfg;
    step_n    = step;
    step_base = '0;
    pat_inc   = (pattern == PAT_W'(NUM_PATTERNS - 1)) ? '0 : pattern + PAT_W'(1);
    pat_sel   = PAT_W'(32'(SW[2:0]) % NUM_PATTERNS);
    if (boundary_c) begin
      if (SW[8]) begin
        state_n = ST_HOLD;
      end else if (SW[9]) begin
        state_n   = ST_AUTO;
        cfg_n     = SW[7:3];
        // A fresh entry into AUTO starts counting from zero
        step_base = (state == ST_AUTO) ? step : '0;
        if ((step_base == STEP_W'(FRAMES_PER_STEP - 1)) || adv_c) begin
          pattern_n = pat_inc;
          step_n    = '0;
        end else begin
          step_n = step_base + STEP_W'(1);
        end
      end else begin
        state_n   = ST_MANUAL;
        cfg_n     = SW[7:3];
        step_n    = '0;
        pattern_n = adv_c ? pat_inc : pat_sel;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pattern     <= '0;
      cfg         <= '0;
      step        <= '0;
      auto_mode   <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      timing_err  <= 1'b0;
    end else begin
      pattern     <= pattern_n;
      cfg         <= cfg_n;
      step        <= step_n;
      auto_mode   <= (state_n == ST_AUTO);
      frame_start <= boundary_c;
      if (boundary_c) begin
        frame_count <= frame_count + 16'(1);
      end
      if (edge_c && vActive) begin
        timing_err <= 1'b1;
      end
    end
  end

endmodule
